// File: rtl/ipf_pkg.sv
// rtl/ipf_pkg.sv - shared codes, FSM states and per-kernel-size schedule tables for the IPF feeder
package ipf_pkg;

  localparam logic [1:0] CTRL_END   = 2'd0;
  localparam logic [1:0] CTRL_START = 2'd1;
  localparam logic [1:0] CTRL_HOLD  = 2'd2;

  localparam logic [1:0] WSIZE_3X3 = 2'd0;
  localparam logic [1:0] WSIZE_5X5 = 2'd1;
  localparam logic [1:0] WSIZE_7X7 = 2'd2;
  localparam logic [1:0] WSIZE_ILL = 2'd3;

  localparam logic [4:0] FULL_PASS_LEN = 5'd16;
  localparam logic [4:0] HALF_PASS_LEN = 5'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_PRE,
    S_RUN,
    S_DRAIN,
    S_END,
    S_WAITFIN
  } state_t;

  function automatic logic [4:0] wn_of(input logic [1:0] ws);
    case (ws)
      WSIZE_3X3: return 5'd18;
      WSIZE_5X5: return 5'd25;
      WSIZE_7X7: return 5'd25;
      default:   return 5'd1;
    endcase
  endfunction

  function automatic logic [2:0] pre_len_of(input logic [1:0] ws);
    case (ws)
      WSIZE_3X3: return 3'd2;
      WSIZE_5X5: return 3'd4;
      WSIZE_7X7: return 3'd6;
      default:   return 3'd1;
    endcase
  endfunction

  function automatic logic [2:0] pass_count_of(input logic [1:0] ws, input logic st);
    case (ws)
      WSIZE_3X3: return st ? 3'd1 : 3'd2;
      WSIZE_5X5: return st ? 3'd1 : 3'd4;
      WSIZE_7X7: return st ? 3'd2 : 3'd4;
      default:   return 3'd1;
    endcase
  endfunction

  function automatic logic [4:0] first_len_of(input logic [1:0] ws);
    return FULL_PASS_LEN - {2'b00, pre_len_of(ws)};
  endfunction

  // 3x3 stride1 streams full 16-word passes every time; all others overlap to 8 after the first.
  function automatic logic [4:0] later_len_of(input logic [1:0] ws, input logic st);
    if (ws == WSIZE_3X3 && !st)
      return first_len_of(ws);
    return HALF_PASS_LEN - {2'b00, pre_len_of(ws)};
  endfunction

endpackage

// File: rtl/ipf_pass_sched.sv
// rtl/ipf_pass_sched.sv - combinational per-pass lookup: preload length, run length, round/group select
module ipf_pass_sched
  import ipf_pkg::*;
(
  input  logic [1:0] wsize,
  input  logic       stride,
  input  logic [1:0] pass_idx,
  output logic [2:0] pre_len,
  output logic [4:0] run_len,
  output logic [2:0] wround,
  output logic [3:0] wgroup_base,
  output logic       last_pass
);

  always_comb begin
    pre_len     = pre_len_of(wsize);
    run_len     = (pass_idx == 2'd0) ? first_len_of(wsize) : later_len_of(wsize, stride);
    last_pass   = ({1'b0, pass_idx} == pass_count_of(wsize, stride) - 3'd1);
    wround      = 3'd0;
    wgroup_base = 4'd0;
    // 3x3 stride1 splits work by group, larger kernels split by weight round
    if (!stride) begin
      case (wsize)
        WSIZE_3X3: wgroup_base = {2'b00, pass_idx};
        WSIZE_5X5: wround      = {2'b00, pass_idx[0]};
        WSIZE_7X7: wround      = {1'b0, pass_idx};
        default:   wround      = 3'd0;
      endcase
    end else if (wsize == WSIZE_7X7) begin
      wround = {1'b0, pass_idx};
    end
  end

endmodule

// File: rtl/ipf_stream_feeder.sv
// rtl/ipf_stream_feeder.sv - sequences weight/image buffer words into the IPF convolution engine
module ipf_stream_feeder
  import ipf_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int W_DEPTH = 25,
  parameter int I_DEPTH = 8,
  parameter int DRAIN_N = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       go,
  input  logic [1:0]                 cfg_wsize,
  input  logic                       cfg_stride,
  input  logic [1:0]                 cfg_rlpad,
  output logic [$clog2(W_DEPTH)-1:0] w_rd_addr,
  input  logic [DATA_W-1:0]          w_rd_data,
  output logic [$clog2(I_DEPTH)-1:0] i_rd_addr,
  input  logic [DATA_W-1:0]          i_rd_data,
  output logic [1:0]                 ctrl,
  output logic                       w_valid,
  output logic [DATA_W-1:0]          w_data,
  output logic                       i_valid,
  output logic [DATA_W-1:0]          i_data,
  output logic [1:0]                 Wsize,
  output logic                       stride,
  output logic [1:0]                 RLPadding,
  output logic [3:0]                 wgroup,
  output logic [2:0]                 wround,
  input  logic                       ipf_finish,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int W_AW = $clog2(W_DEPTH);
  localparam int I_AW = $clog2(I_DEPTH);

  state_t          state, state_n;
  logic [4:0]      cnt, cnt_n;
  logic [1:0]      pass_idx, pass_n;
  logic [I_AW-1:0] i_addr, i_addr_n, i_addr_inc;

  logic            w_issue, i_issue, cfg_load;
  logic [1:0]      ctrl_n;
  logic [3:0]      wgroup_n;
  logic [2:0]      wround_n;
  logic            busy_n, done_n, err_n;
  logic [DATA_W-1:0] w_hold, i_hold;

  logic [2:0]      pre_len;
  logic [4:0]      run_len;
  logic [2:0]      sched_wround;
  logic [3:0]      wgroup_base;
  logic            last_pass;

  ipf_pass_sched u_sched (
    .wsize       (Wsize),
    .stride      (stride),
    .pass_idx    (pass_idx),
    .pre_len     (pre_len),
    .run_len     (run_len),
    .wround      (sched_wround),
    .wgroup_base (wgroup_base),
    .last_pass   (last_pass)
  );

  assign w_rd_addr  = W_AW'(cnt);
  assign i_rd_addr  = i_addr;
  assign i_addr_inc = (i_addr == I_AW'(I_DEPTH - 1)) ? '0 : i_addr + 1'b1;

  // Buffers are registered sync-read RAMs, so their output is already a flop; the strobe
  // (registered here) selects it on the cycle it is valid, otherwise the last word is held.
  assign w_data = w_valid ? w_rd_data : w_hold;
  assign i_data = i_valid ? i_rd_data : i_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      pass_idx <= '0;
      i_addr   <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      pass_idx <= pass_n;
      i_addr   <= i_addr_n;
    end
  end

  // Everything decided here lands on the IPF pins one cycle later, aligned with the read data.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    pass_n   = pass_idx;
    i_addr_n = i_addr;
    w_issue  = 1'b0;
    i_issue  = 1'b0;
    ctrl_n   = CTRL_HOLD;
    wgroup_n = wgroup;
    wround_n = wround;
    busy_n   = busy;
    done_n   = 1'b0;
    err_n    = err;
    cfg_load = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) begin
          cfg_load = 1'b1;
          if (cfg_wsize == WSIZE_ILL) begin
            err_n  = 1'b1;
            done_n = 1'b1;
          end else begin
            err_n   = 1'b0;
            busy_n  = 1'b1;
            cnt_n   = '0;
            state_n = S_WLOAD;
          end
        end
      end
      S_WLOAD: begin
        w_issue = 1'b1;
        if (cnt == wn_of(Wsize) - 5'd1) begin
          state_n  = S_PRE;
          cnt_n    = '0;
          pass_n   = '0;
          i_addr_n = '0;
        end else begin
          cnt_n = cnt + 5'd1;
        end
      end
      S_PRE: begin
        i_issue  = 1'b1;
        i_addr_n = i_addr_inc;
        if (!stride)
          wgroup_n = wgroup_base;
        if (cnt == {2'b00, pre_len} - 5'd1) begin
          state_n = S_RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 5'd1;
        end
      end
      S_RUN: begin
        i_issue  = 1'b1;
        ctrl_n   = CTRL_START;
        i_addr_n = i_addr_inc;
        wround_n = sched_wround;
        wgroup_n = stride ? {3'b000, cnt[0]} : wgroup_base;
        if (cnt == run_len - 5'd1) begin
          cnt_n    = '0;
          i_addr_n = '0;
          if (last_pass) begin
            state_n = S_DRAIN;
          end else begin
            state_n = S_PRE;
            pass_n  = pass_idx + 2'd1;
          end
        end else begin
          cnt_n = cnt + 5'd1;
        end
      end
      S_DRAIN: begin
        if (cnt == 5'(DRAIN_N - 1)) begin
          state_n = S_END;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 5'd1;
        end
      end
      S_END: begin
        ctrl_n  = CTRL_END;
        state_n = S_WAITFIN;
      end
      S_WAITFIN: begin
        ctrl_n = CTRL_END;
        if (ipf_finish) begin
          ctrl_n  = CTRL_HOLD;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl      <= CTRL_HOLD;
      w_valid   <= 1'b0;
      i_valid   <= 1'b0;
      w_hold    <= '0;
      i_hold    <= '0;
      wgroup    <= '0;
      wround    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      Wsize     <= '0;
      stride    <= 1'b0;
      RLPadding <= '0;
    end else begin
      ctrl    <= ctrl_n;
      w_valid <= w_issue;
      i_valid <= i_issue;
      if (w_valid)
        w_hold <= w_rd_data;
      if (i_valid)
        i_hold <= i_rd_data;
      wgroup  <= wgroup_n;
      wround  <= wround_n;
      busy    <= busy_n;
      done    <= done_n;
      err     <= err_n;
      if (cfg_load) begin
        Wsize     <= cfg_wsize;
        stride    <= cfg_stride;
        RLPadding <= cfg_rlpad;
      end
    end
  end

endmodule

// File: tb/tb_ipf_stream_feeder.sv
// tb/tb_ipf_stream_feeder.sv - randomized self-checking bench for ipf_stream_feeder
module tb_ipf_stream_feeder;

  localparam logic [1:0] C_END = 2'd0, C_START = 2'd1, C_HOLD = 2'd2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, go, cfg_stride, ipf_finish;
  logic [1:0]  cfg_wsize, cfg_rlpad;
  logic [4:0]  w_rd_addr;
  logic [2:0]  i_rd_addr;
  logic [63:0] w_rd_data, i_rd_data, w_data, i_data;
  logic [1:0]  ctrl, Wsize, RLPadding;
  logic        w_valid, i_valid, stride, busy, done, err;
  logic [3:0]  wgroup;
  logic [2:0]  wround;

  logic [63:0] wbuf [0:31];
  logic [63:0] ibuf [0:7];
  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct { logic [1:0] ctrl; logic [63:0] data; int grp; int rnd; } iexp_t;
  typedef struct packed { logic [1:0] ctrl; logic [63:0] data; logic [3:0] grp; logic [2:0] rnd; } iobs_t;

  ipf_stream_feeder dut (
    .clk(clk), .rst(rst), .go(go), .cfg_wsize(cfg_wsize), .cfg_stride(cfg_stride),
    .cfg_rlpad(cfg_rlpad), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
    .i_rd_addr(i_rd_addr), .i_rd_data(i_rd_data), .ctrl(ctrl), .w_valid(w_valid),
    .w_data(w_data), .i_valid(i_valid), .i_data(i_data), .Wsize(Wsize), .stride(stride),
    .RLPadding(RLPadding), .wgroup(wgroup), .wround(wround), .ipf_finish(ipf_finish),
    .busy(busy), .done(done), .err(err)
  );

  always @(posedge clk) begin
    w_rd_data <= wbuf[w_rd_addr];
    i_rd_data <= ibuf[i_rd_addr];
  end

  task automatic fill_buffers();
    for (int i = 0; i < 32; i++) wbuf[i] = {$urandom, $urandom};
    for (int i = 0; i < 8; i++) ibuf[i] = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    rst = 1'b1; go = 1'b0; ipf_finish = 1'b0;
    cfg_wsize = 2'd0; cfg_stride = 1'b0; cfg_rlpad = 2'd0;
    fill_buffers();
    repeat (3) @(negedge clk);
    total_cnt++; if (ctrl !== C_HOLD) $display("FAIL reset_ctrl: got %0d want %0d", ctrl, C_HOLD); else pass_cnt++;
    total_cnt++; if ({w_valid, i_valid, busy, done, err} !== 5'b0) $display("FAIL reset_flags: got %b want 00000", {w_valid, i_valid, busy, done, err}); else pass_cnt++;
    total_cnt++; if ({w_data, i_data} !== 128'b0) $display("FAIL reset_data: got %0h want 0", {w_data, i_data}); else pass_cnt++;
    total_cnt++; if ({Wsize, stride, RLPadding, wgroup, wround, w_rd_addr, i_rd_addr} !== 22'b0) $display("FAIL reset_cfg: got %0h want 0", {Wsize, stride, RLPadding, wgroup, wround, w_rd_addr, i_rd_addr}); else pass_cnt++;
    rst = 1'b0;
  endtask

  // Full run: builds the expected word stream from the pass rules, launches, records, compares.
  task automatic run_case(input int ws, input int st, input bit poke_go);
    logic [63:0] exp_w[$];
    logic [63:0] obs_w[$];
    iexp_t       exp_i[$];
    iobs_t       obs_i[$];
    iexp_t       e;
    logic [1:0]  pad;
    int p, np, rl, rnd, last_grp, last_rnd;
    int cyc, end_cyc, fin_cyc, done_cyc, drain, wait_bad, busy_bad, done_cnt;
    bit ended;
    fill_buffers();
    p  = 2 * ws + 2;
    np = st ? ((ws == 2) ? 2 : 1) : ((ws == 0) ? 2 : 4);
    for (int i = 0; i < ((ws == 0) ? 18 : 25); i++) exp_w.push_back(wbuf[i]);
    last_grp = -1; last_rnd = -1;
    for (int ps = 0; ps < np; ps++) begin
      rl  = (ps == 0 || (ws == 0 && st == 0)) ? 16 - p : 8 - p;
      rnd = (st == 0 && ws == 1) ? ps % 2 : ((ws == 2) ? ps : 0);
      for (int k = 0; k < p + rl; k++) begin
        e.data = ibuf[k % 8];
        e.ctrl = (k < p) ? C_HOLD : C_START;
        if (k < p) begin
          e.grp = st ? last_grp : ((ws == 0) ? ps : 0);
          e.rnd = last_rnd;
        end else begin
          e.grp = st ? (k - p) % 2 : ((ws == 0) ? ps : 0);
          e.rnd = rnd;
          last_grp = e.grp; last_rnd = rnd;
        end
        exp_i.push_back(e);
      end
    end
    pad = 2'($urandom);
    @(negedge clk);
    go = 1'b1; cfg_wsize = 2'(ws); cfg_stride = 1'(st); cfg_rlpad = pad;
    @(negedge clk);
    go = 1'b0; cfg_wsize = 2'($urandom); cfg_stride = 1'($urandom); cfg_rlpad = 2'($urandom);
    total_cnt++; if ({busy, err} !== 2'b10) $display("FAIL go_accept ws%0d s%0d: busy,err got %b want 10", ws, st, {busy, err}); else pass_cnt++;
    cyc = 0; ended = 0; end_cyc = 0; fin_cyc = -1; done_cyc = -1;
    drain = 0; wait_bad = 0; busy_bad = 0; done_cnt = 0;
    while (cyc < 1500 && (done_cyc < 0 || cyc < done_cyc + 5)) begin
      @(negedge clk);
      cyc++;
      if (w_valid) obs_w.push_back(w_data);
      if (i_valid) obs_i.push_back({ctrl, i_data, wgroup, wround});
      if (obs_i.size() > 0 && !i_valid && !ended && ctrl === C_HOLD) drain++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          total_cnt++; if (busy !== 1'b0 || ctrl !== C_HOLD) $display("FAIL done_state ws%0d: busy,ctrl got %b,%0d want 0,2", ws, busy, ctrl); else pass_cnt++;
          total_cnt++; if (done_cyc !== fin_cyc + 1) $display("FAIL done_latency ws%0d: got cycle %0d want %0d", ws, done_cyc, fin_cyc + 1); else pass_cnt++;
        end
      end else if (done_cyc < 0 && busy !== 1'b1) busy_bad++;
      if (ended && done_cyc < 0 && ctrl !== C_END) wait_bad++;
      if (!ended && ctrl === C_END) begin ended = 1; end_cyc = cyc; end
      go = poke_go && (cyc == 30);
      if (ended && fin_cyc < 0 && cyc == end_cyc + 50) begin ipf_finish = 1'b1; fin_cyc = cyc; end
      if (done_cyc >= 0) ipf_finish = 1'b0;
    end
    go = 1'b0; ipf_finish = 1'b0;
    total_cnt++; if (done_cyc < 0) $display("FAIL done_timeout ws%0d s%0d: got none want pulse", ws, st); else pass_cnt++;
    total_cnt++; if (done_cnt !== 1) $display("FAIL done_count ws%0d: got %0d want 1", ws, done_cnt); else pass_cnt++;
    total_cnt++; if (obs_w.size() !== exp_w.size()) $display("FAIL w_count ws%0d: got %0d want %0d", ws, obs_w.size(), exp_w.size()); else pass_cnt++;
    for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
      total_cnt++; if (obs_w[i] !== exp_w[i]) $display("FAIL w_word[%0d] ws%0d: got %0h want %0h", i, ws, obs_w[i], exp_w[i]); else pass_cnt++;
    end
    total_cnt++; if (obs_i.size() !== exp_i.size()) $display("FAIL i_count ws%0d s%0d: got %0d want %0d", ws, st, obs_i.size(), exp_i.size()); else pass_cnt++;
    for (int i = 0; i < obs_i.size() && i < exp_i.size(); i++) begin
      total_cnt++; if ({obs_i[i].ctrl, obs_i[i].data} !== {exp_i[i].ctrl, exp_i[i].data}) $display("FAIL i_word[%0d] ws%0d s%0d: got ctrl %0d data %0h want ctrl %0d data %0h", i, ws, st, obs_i[i].ctrl, obs_i[i].data, exp_i[i].ctrl, exp_i[i].data); else pass_cnt++;
      if (exp_i[i].grp >= 0) begin
        total_cnt++; if (obs_i[i].grp !== 4'(exp_i[i].grp)) $display("FAIL wgroup[%0d] ws%0d s%0d: got %0d want %0d", i, ws, st, obs_i[i].grp, exp_i[i].grp); else pass_cnt++;
      end
      if (exp_i[i].rnd >= 0) begin
        total_cnt++; if (obs_i[i].rnd !== 3'(exp_i[i].rnd)) $display("FAIL wround[%0d] ws%0d s%0d: got %0d want %0d", i, ws, st, obs_i[i].rnd, exp_i[i].rnd); else pass_cnt++;
      end
    end
    total_cnt++; if (drain !== 10) $display("FAIL drain ws%0d: got %0d want 10", ws, drain); else pass_cnt++;
    total_cnt++; if (wait_bad !== 0) $display("FAIL end_hold ws%0d: got %0d bad cycles want 0", ws, wait_bad); else pass_cnt++;
    total_cnt++; if (busy_bad !== 0) $display("FAIL busy_hold ws%0d: got %0d low cycles want 0", ws, busy_bad); else pass_cnt++;
    total_cnt++; if ({Wsize, stride, RLPadding, err} !== {2'(ws), 1'(st), pad, 1'b0}) $display("FAIL cfg_latch ws%0d: got %b want %b", ws, {Wsize, stride, RLPadding, err}, {2'(ws), 1'(st), pad, 1'b0}); else pass_cnt++;
  endtask

  task automatic test_3x3_s1();      run_case(0, 0, 1'b0); endtask
  task automatic test_5x5_s1();      run_case(1, 0, 1'b0); endtask
  task automatic test_7x7_s2();      run_case(2, 1, 1'b1); endtask
  task automatic test_other_sizes(); run_case(2, 0, 1'b1); run_case(0, 1, 1'b0); run_case(1, 1, 1'b1); endtask

  task automatic test_illegal();
    int bad;
    @(negedge clk);
    go = 1'b1; cfg_wsize = 2'd3; cfg_stride = 1'($urandom);
    @(negedge clk);
    go = 1'b0;
    total_cnt++; if ({done, err, busy} !== 3'b110) $display("FAIL illegal_resp: done,err,busy got %b want 110", {done, err, busy}); else pass_cnt++;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (w_valid || i_valid || done || ctrl !== C_HOLD || busy) bad++;
    end
    total_cnt++; if (bad !== 0) $display("FAIL illegal_quiet: got %0d active cycles want 0", bad); else pass_cnt++;
    total_cnt++; if (err !== 1'b1) $display("FAIL illegal_sticky: got %b want 1", err); else pass_cnt++;
  endtask

  task automatic test_rst_mid_run();
    int waited, bad;
    fill_buffers();
    @(negedge clk);
    go = 1'b1; cfg_wsize = 2'd1; cfg_stride = 1'b0;
    @(negedge clk);
    go = 1'b0;
    waited = 0;
    while (ctrl !== C_START && waited < 200) begin @(negedge clk); waited++; end
    total_cnt++; if (ctrl !== C_START) $display("FAIL reach_run: got ctrl %0d want %0d", ctrl, C_START); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++; if ({ctrl, busy, i_valid, w_valid, wround, wgroup} !== {C_HOLD, 10'b0}) $display("FAIL rst_abort: got %b want %b", {ctrl, busy, i_valid, w_valid, wround, wgroup}, {C_HOLD, 10'b0}); else pass_cnt++;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (w_valid || i_valid || done || busy || ctrl !== C_HOLD) bad++;
    end
    total_cnt++; if (bad !== 0) $display("FAIL rst_no_end: got %0d active cycles want 0", bad); else pass_cnt++;
    rst = 1'b1; go = 1'b1; cfg_wsize = 2'd0;
    @(negedge clk);
    rst = 1'b0; go = 1'b0;
    bad = 0;
    repeat (10) begin
      if (w_valid || busy || ctrl !== C_HOLD) bad++;
      @(negedge clk);
    end
    total_cnt++; if (bad !== 0) $display("FAIL rst_beats_go: got %0d active cycles want 0", bad); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_3x3_s1();
    test_5x5_s1();
    test_7x7_s2();
    test_illegal();
    test_other_sizes();
    test_rst_mid_run();
    test_3x3_s1();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
